// File: rtl/ixc_clkgen_pkg.sv
// Shared types for the multi-channel emulated clock generator.
// Lengths are carried at LEN_W bits so that any CNT_W up to LEN_W fits the same config struct.
package ixc_clkgen_pkg;
  localparam int LEN_W = 16;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } chan_state_e;

  typedef struct packed {
    logic en;
    len_t hi;
    len_t lo;
    len_t phase;
  } chan_cfg_t;

  function automatic len_t len_min1(input len_t v);
    return (v == '0) ? len_t'(1) : v;
  endfunction
endpackage

// File: rtl/ixc_clkgen_chan.sv
// One emulated clock channel: IDLE/PHASE/HIGH/LOW dwell FSM, its counter and its active config.
// A config offered on i_apply is taken in IDLE or at the LOW boundary; the boundary then uses the new en.
module ixc_clkgen_chan
  import ixc_clkgen_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_adv,
  input  logic        i_apply,
  input  chan_cfg_t   i_cfg,
  output logic        o_phi,
  output logic        o_rise,
  output logic        o_fall,
  output logic        o_idle,
  output logic        o_at_boundary,
  output chan_state_e o_state
);
  chan_state_e      r_state;
  chan_state_e      w_next;
  logic [CNT_W-1:0] r_cnt;
  chan_cfg_t        r_cfg;
  logic             r_phi;
  logic             r_rise;
  logic             r_fall;
  len_t             w_len;
  logic             w_done;
  logic             w_next_en;

  // State register, dwell counter, active config and registered clock outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cfg   <= '0;
      r_phi   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (i_adv && (r_state != ST_IDLE)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_apply) begin
        r_cfg <= i_cfg;
      end
      r_phi  <= (w_next == ST_HIGH);
      r_rise <= (w_next == ST_HIGH) && (r_state != ST_HIGH);
      r_fall <= (r_state == ST_HIGH) && (w_next != ST_HIGH);
    end
  end

  // Next-state: a config being applied in IDLE holds the channel there for that cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_adv && r_cfg.en && !i_apply) begin
          w_next = (r_cfg.phase != '0) ? ST_PHASE : ST_HIGH;
        end
      end
      ST_PHASE: if (w_done) w_next = ST_HIGH;
      ST_HIGH:  if (w_done) w_next = ST_LOW;
      ST_LOW:   if (w_done) w_next = w_next_en ? ST_HIGH : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Dwell length of the current state and channel status outputs.
  always_comb begin
    w_len = len_t'(1);
    unique case (r_state)
      ST_PHASE: w_len = r_cfg.phase;
      ST_HIGH:  w_len = len_min1(r_cfg.hi);
      ST_LOW:   w_len = len_min1(r_cfg.lo);
      default:  w_len = len_t'(1);
    endcase
    w_done        = i_adv && (len_t'(r_cnt) == (w_len - len_t'(1)));
    w_next_en     = i_apply ? i_cfg.en : r_cfg.en;
    o_at_boundary = (r_state == ST_LOW) && w_done;
    o_idle        = (r_state == ST_IDLE);
    o_state       = r_state;
    o_phi         = r_phi;
    o_rise        = r_rise;
    o_fall        = r_fall;
  end
endmodule

// File: rtl/ixc_clock_gen.sv
// NCH independent emulated clocks sharing one pending configuration slot.
// Handshake: a request transfers on a rising edge with cfg_valid & cfg_ready; the requester holds all cfg_* until then.
module ixc_clock_gen
  import ixc_clkgen_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 11
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 adv,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic                                 cfg_en,
  input  logic [CNT_W-1:0]                     cfg_hi,
  input  logic [CNT_W-1:0]                     cfg_lo,
  input  logic [CNT_W-1:0]                     cfg_phase,
  output logic [NCH-1:0]                       phi,
  output logic [NCH-1:0]                       rise,
  output logic [NCH-1:0]                       fall,
  output logic [NCH-1:0]                       active,
  output logic [2*NCH-1:0]                     dbg_state
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic            r_pend_valid;
  logic [CH_W-1:0] r_pend_ch;
  chan_cfg_t       r_pend_cfg;
  logic [NCH-1:0]  w_apply;
  logic [NCH-1:0]  w_idle;
  logic [NCH-1:0]  w_bound;
  logic            w_bad_ch;

  // A channel index beyond NCH could never be applied, so it is retired instead of blocking the slot.
  assign w_bad_ch  = (32'(r_pend_ch) >= NCH);
  assign cfg_ready = !r_pend_valid;
  assign active    = ~w_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_ch    <= '0;
      r_pend_cfg   <= '0;
    end else if (r_pend_valid) begin
      if ((|w_apply) || w_bad_ch) begin
        r_pend_valid <= 1'b0;
      end
    end else if (cfg_valid) begin
      r_pend_valid     <= 1'b1;
      r_pend_ch        <= cfg_ch;
      r_pend_cfg.en    <= cfg_en;
      r_pend_cfg.hi    <= len_t'(cfg_hi);
      r_pend_cfg.lo    <= len_t'(cfg_lo);
      r_pend_cfg.phase <= len_t'(cfg_phase);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    chan_state_e w_state;

    assign w_apply[g] = r_pend_valid && (32'(r_pend_ch) == g) && (w_idle[g] || w_bound[g]);
    assign dbg_state[2*g +: 2] = w_state;

    ixc_clkgen_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_adv        (adv),
      .i_apply      (w_apply[g]),
      .i_cfg        (r_pend_cfg),
      .o_phi        (phi[g]),
      .o_rise       (rise[g]),
      .o_fall       (fall[g]),
      .o_idle       (w_idle[g]),
      .o_at_boundary(w_bound[g]),
      .o_state      (w_state)
    );
  end
endmodule
